// File: rtl/spi_dac_serializer.sv
// SPI mode-0 DAC serializer: MSB-first frames on sclk/sdo/cs_n with overrun reporting.
// Define SPI_DOUBLE_BUFFER_EN to add a one-entry holding register for strobes that arrive mid-frame.
module spi_dac_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_strobe_i,
  output logic                  sclk_o,
  output logic                  sdo_o,
  output logic                  cs_n_o,
  output logic                  busy_o,
  output logic                  done_strobe_o,
  output logic                  overrun_strobe_o
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, GAP} state_t;

  state_t                state, state_nxt;
  logic [DIV_W-1:0]      div_cnt, div_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  phase_end;
  logic                  sclk_nxt, sdo_nxt, cs_n_nxt, busy_nxt, done_nxt, overrun_nxt;
`ifdef SPI_DOUBLE_BUFFER_EN
  logic [DATA_WIDTH-1:0] buf_data, buf_data_nxt;
  logic                  buf_full, buf_full_nxt;
  logic                  drain;
`endif

  // div_cnt holds the cycles left in the current phase minus one
  assign phase_end = (div_cnt == '0);

  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    bit_nxt     = bit_cnt;
    shreg_nxt   = shreg;
    overrun_nxt = 1'b0;
`ifdef SPI_DOUBLE_BUFFER_EN
    buf_data_nxt = buf_data;
    buf_full_nxt = buf_full;
    drain        = 1'b0;
`endif
    if (state != IDLE && !phase_end) begin
      div_nxt = div_cnt - DIV_W'(1);
    end

    case (state)
      IDLE: begin
        if (data_valid_strobe_i) begin
          shreg_nxt = data_i;
          bit_nxt   = BIT_LOAD;
          div_nxt   = DIV_LOAD;
          state_nxt = LEAD;
        end
      end
      LEAD: begin
        if (phase_end) begin
          state_nxt = HIGH;
          div_nxt   = DIV_LOAD;
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_nxt = LOW;
          div_nxt   = DIV_LOAD;
          // after the last bit the LOW phase is a trailing hold, so sdo keeps the LSB
          if (bit_cnt != '0) begin
            shreg_nxt = {shreg[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          div_nxt = DIV_LOAD;
          if (bit_cnt != '0) begin
            state_nxt = HIGH;
            bit_nxt   = bit_cnt - BIT_W'(1);
          end else begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          state_nxt = IDLE;
`ifdef SPI_DOUBLE_BUFFER_EN
          if (buf_full) begin
            drain        = 1'b1;
            buf_full_nxt = 1'b0;
            shreg_nxt    = buf_data;
            bit_nxt      = BIT_LOAD;
            div_nxt      = DIV_LOAD;
            state_nxt    = LEAD;
          end else if (data_valid_strobe_i) begin
            shreg_nxt = data_i;
            bit_nxt   = BIT_LOAD;
            div_nxt   = DIV_LOAD;
            state_nxt = LEAD;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    // strobes arriving while a frame is in flight
    if (data_valid_strobe_i && state != IDLE) begin
`ifdef SPI_DOUBLE_BUFFER_EN
      if (!(state == GAP && phase_end && !buf_full)) begin
        buf_data_nxt = data_i;
        buf_full_nxt = 1'b1;
        overrun_nxt  = buf_full && !drain;
      end
`else
      overrun_nxt = 1'b1;
`endif
    end

    sclk_nxt = (state_nxt == HIGH);
    cs_n_nxt = (state_nxt == IDLE) || (state_nxt == GAP);
    busy_nxt = (state_nxt != IDLE);
    sdo_nxt  = !cs_n_nxt && shreg_nxt[DATA_WIDTH-1];
    done_nxt = (state_nxt == GAP) && (state != GAP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      div_cnt          <= '0;
      bit_cnt          <= '0;
      sclk_o           <= 1'b0;
      sdo_o            <= 1'b0;
      cs_n_o           <= 1'b1;
      busy_o           <= 1'b0;
      done_strobe_o    <= 1'b0;
      overrun_strobe_o <= 1'b0;
`ifdef SPI_DOUBLE_BUFFER_EN
      buf_full         <= 1'b0;
`endif
    end else begin
      state            <= state_nxt;
      div_cnt          <= div_nxt;
      bit_cnt          <= bit_nxt;
      sclk_o           <= sclk_nxt;
      sdo_o            <= sdo_nxt;
      cs_n_o           <= cs_n_nxt;
      busy_o           <= busy_nxt;
      done_strobe_o    <= done_nxt;
      overrun_strobe_o <= overrun_nxt;
`ifdef SPI_DOUBLE_BUFFER_EN
      buf_full         <= buf_full_nxt;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    shreg <= shreg_nxt;
`ifdef SPI_DOUBLE_BUFFER_EN
    buf_data <= buf_data_nxt;
`endif
  end

endmodule
